// File: rtl/dot_product_accumulator_9bits_pkg.sv
// Shared types and helpers for the PIRDSP product accumulator.
// Holds the FSM state type, product width and product extension.
package pirdsp_acc_pkg;

    localparam int PRODUCT_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Returns the product extended to w bits (w <= 64), upper bits cleared.
    function automatic logic [63:0] extend(
        input logic [PRODUCT_WIDTH-1:0] p,
        input logic                     s,
        input int unsigned              w
    );
        logic [63:0] r;
        r = {{(64-PRODUCT_WIDTH){s & p[PRODUCT_WIDTH-1]}}, p};
        if (w < 64)
            r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_9bits_if.sv
// Product-in / result-out handshake bundle for the accumulator.
// master drives beats and takes results; slave is the accumulator.
interface dot_product_accumulator_9bits_if
    import pirdsp_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 36,
    parameter int CNT_WIDTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [PRODUCT_WIDTH-1:0] in_product;
    logic                     in_signed;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_WIDTH-1:0]     out_acc;
    logic                     out_overflow;
    logic [CNT_WIDTH-1:0]     out_count;

    modport master (
        output in_valid, in_product, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_overflow, out_count
    );

    modport slave (
        input  in_valid, in_product, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_overflow, out_count
    );
endinterface

// File: rtl/dot_product_accumulator_9bits_sat_counter.sv
// Saturating beat counter: load-to-1 on a vector's first beat,
// increment on later beats, stick at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count_nxt
);
    logic [CNT_WIDTH-1:0] count;

    always_comb begin
        count_nxt = count;
        if (load)
            count_nxt = CNT_WIDTH'(1);
        else if (inc && count != '1)
            count_nxt = count + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= count_nxt;
    end
endmodule

// File: rtl/dot_product_accumulator_9bits.sv
// Dot-product accumulator fed by the 9x9 PIRDSP multiplier.
// Sums one 18-bit product per beat; presents sum/overflow/count per vector.
import pirdsp_acc_pkg::*;

module dot_product_accumulator_9bits #(
    parameter int ACC_WIDTH = 36,
    parameter int CNT_WIDTH = 8
) (
    input logic clk,
    input logic reset,
    dot_product_accumulator_9bits_if.slave bus
);
    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, ext, base;
    logic [ACC_WIDTH:0]   sum;
    logic                 mode, mode_q;
    logic                 ovf_q, ovf_nxt, ovf_beat;
    logic                 first, beat, taken, done;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [ACC_WIDTH-1:0] res_acc;
    logic                 res_ovf;
    logic [CNT_WIDTH-1:0] res_cnt;

    assign bus.in_ready  = (state != HOLD) | bus.out_ready;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_acc      = res_acc;
    assign bus.out_overflow = res_ovf;
    assign bus.out_count    = res_cnt;

    assign beat  = bus.in_valid & bus.in_ready;
    assign taken = (state == HOLD) & bus.out_ready;
    assign done  = beat & bus.in_last;

    // Any beat accepted outside ACCUM opens a new vector.
    assign first = (state != ACCUM);
    assign mode  = first ? bus.in_signed : mode_q;
    assign ext   = ACC_WIDTH'(extend(bus.in_product, mode, ACC_WIDTH));
    assign base  = first ? '0 : acc;

    // One extra bit: sign-extended in signed mode, carry in unsigned mode.
    assign sum = {mode & base[ACC_WIDTH-1], base}
               + {mode & ext[ACC_WIDTH-1], ext};

    assign ovf_beat = mode ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1])
                           : sum[ACC_WIDTH];
    assign ovf_nxt  = (~first & ovf_q) | ovf_beat;

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (beat & first),
        .inc      (beat & ~first),
        .count_nxt(cnt_nxt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, ACCUM:
                if (beat)
                    state_nxt = bus.in_last ? HOLD : ACCUM;
            HOLD:
                if (taken)
                    state_nxt = !beat       ? IDLE :
                                bus.in_last ? HOLD : ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            res_acc <= '0;
            res_ovf <= 1'b0;
            res_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                acc    <= sum[ACC_WIDTH-1:0];
                mode_q <= mode;
                ovf_q  <= ovf_nxt;
            end
            if (done) begin
                res_acc <= sum[ACC_WIDTH-1:0];
                res_ovf <= ovf_nxt;
                res_cnt <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_accumulator_9bits.sv
// Directed bench for dot_product_accumulator_9bits (36-bit and 19-bit).
// Vector table plus hand sequences for stalls, resets and wrap.
module tb_dot_product_accumulator_9bits;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dot_product_accumulator_9bits_if #(.ACC_WIDTH(36), .CNT_WIDTH(8)) b36 ();
    dot_product_accumulator_9bits_if #(.ACC_WIDTH(19), .CNT_WIDTH(8)) b19 ();

    dot_product_accumulator_9bits #(
        .ACC_WIDTH(36), .CNT_WIDTH(8)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(b36.slave)
    );

    dot_product_accumulator_9bits #(
        .ACC_WIDTH(19), .CNT_WIDTH(8)
    ) u_dut19 (
        .clk(clk), .reset(reset), .bus(b19.slave)
    );

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][17:0] p;
        logic [3:0]       s;
        logic [35:0]      acc;
        logic             ovf;
        logic [7:0]       cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [17:0] p,
                         input logic s, input logic l);
        if (w == 0) begin
            b36.in_valid = v; b36.in_product = p;
            b36.in_signed = s; b36.in_last = l;
        end else begin
            b19.in_valid = v; b19.in_product = p;
            b19.in_signed = s; b19.in_last = l;
        end
    endtask

    // Presents a beat and returns #1 after the edge that accepts it.
    task automatic beat(input int w, input logic [17:0] p,
                        input logic s, input logic l);
        logic rdy;
        drive(w, 1'b1, p, s, l);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rdy = (w == 0) ? b36.in_ready : b19.in_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        checks++;
        errors++;
        $display("FAIL beat_timeout got in_ready=0 expected 1");
    endtask

    task automatic result(input int w, input string nm,
                          input logic [35:0] acc, input logic ovf,
                          input logic [7:0] cnt);
        @(negedge clk);
        if (w == 0) begin
            chk({nm, "_valid"}, 64'(b36.out_valid), 64'd1);
            chk({nm, "_acc"}, 64'(b36.out_acc), 64'(acc));
            chk({nm, "_ovf"}, 64'(b36.out_overflow), 64'(ovf));
            chk({nm, "_cnt"}, 64'(b36.out_count), 64'(cnt));
        end else begin
            chk({nm, "_valid"}, 64'(b19.out_valid), 64'd1);
            chk({nm, "_acc"}, 64'(b19.out_acc), 64'(acc));
            chk({nm, "_ovf"}, 64'(b19.out_overflow), 64'(ovf));
            chk({nm, "_cnt"}, 64'(b19.out_count), 64'(cnt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{n: 3'd3, p: {18'h0, 18'h3FFFE, 18'h00005, 18'h3FFFF},
                   s: 4'b1111, acc: 36'd2, ovf: 1'b0, cnt: 8'd3};
        tbl[1] = '{n: 3'd1, p: {18'h0, 18'h0, 18'h0, 18'h3FFFF},
                   s: 4'b0000, acc: 36'd262143, ovf: 1'b0, cnt: 8'd1};
        tbl[2] = '{n: 3'd2, p: {18'h0, 18'h0, 18'h20000, 18'h20000},
                   s: 4'b0001, acc: 36'hFFFFC0000, ovf: 1'b0, cnt: 8'd2};
        tbl[3] = '{n: 3'd3, p: {18'h0, 18'h1, 18'h1, 18'h1},
                   s: 4'b0000, acc: 36'd3, ovf: 1'b0, cnt: 8'd3};
        tbl[4] = '{n: 3'd2, p: {18'h0, 18'h0, 18'h1FFFF, 18'h1FFFF},
                   s: 4'b0011, acc: 36'h3FFFE, ovf: 1'b0, cnt: 8'd2};
        tbl[5] = '{n: 3'd2, p: {18'h0, 18'h0, 18'h00003, 18'h3FFFB},
                   s: 4'b0011, acc: 36'hFFFFFFFFE, ovf: 1'b0, cnt: 8'd2};

        reset = 1'b1;
        drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 18'h0, 1'b0, 1'b0);
        b36.out_ready = 1'b1;
        b19.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(b36.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b36.out_valid), 64'd0);
        chk("rst_out_acc", 64'(b36.out_acc), 64'd0);
        chk("rst_out_ovf", 64'(b36.out_overflow), 64'd0);
        chk("rst_out_cnt", 64'(b36.out_count), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'(tbl[i].n); j++)
                beat(0, tbl[i].p[j], tbl[i].s[j], j == int'(tbl[i].n) - 1);
            drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
            result(0, $sformatf("vec%0d", i),
                   tbl[i].acc, tbl[i].ovf, tbl[i].cnt);
            @(posedge clk);
            #1;
        end

        // Back-to-back single-beat vectors, no bubble.
        beat(0, 18'd2, 1'b0, 1'b1);
        drive(0, 1'b1, 18'd5, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_valid", 64'(b36.out_valid), 64'd1);
        chk("b2b_acc", 64'(b36.out_acc), 64'd2);
        chk("b2b_in_ready", 64'(b36.in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
        result(0, "b2b_next", 36'd5, 1'b0, 8'd1);
        @(posedge clk);
        #1;

        // Back-pressure: result held, pending beat refused.
        b36.out_ready = 1'b0;
        beat(0, 18'd3, 1'b0, 1'b0);
        beat(0, 18'd4, 1'b0, 1'b1);
        drive(0, 1'b1, 18'd10, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(b36.in_ready), 64'd0);
            chk("bp_valid", 64'(b36.out_valid), 64'd1);
            chk("bp_acc", 64'(b36.out_acc), 64'd7);
            chk("bp_cnt", 64'(b36.out_count), 64'd2);
        end
        b36.out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 64'(b36.in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
        result(0, "bp_new", 36'd10, 1'b0, 8'd1);
        @(posedge clk);
        #1;

        // Reset after 2 of 4 beats discards the vector.
        beat(0, 18'd1, 1'b0, 1'b0);
        beat(0, 18'd1, 1'b0, 1'b0);
        drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstm_valid", 64'(b36.out_valid), 64'd0);
        chk("rstm_in_ready", 64'(b36.in_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++)
            beat(0, 18'd1, 1'b0, j == 2);
        drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
        result(0, "rstm_next", 36'd3, 1'b0, 8'd3);
        @(posedge clk);
        #1;

        // Reset while a result is held drops it.
        b36.out_ready = 1'b0;
        beat(0, 18'd9, 1'b0, 1'b1);
        drive(0, 1'b0, 18'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rsth_valid", 64'(b36.out_valid), 64'd0);
        chk("rsth_acc", 64'(b36.out_acc), 64'd0);
        b36.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 19-bit accumulator: fits, then wraps with carry-out.
        beat(1, 18'h3FFFF, 1'b0, 1'b0);
        beat(1, 18'h3FFFF, 1'b0, 1'b1);
        drive(1, 1'b0, 18'h0, 1'b0, 1'b0);
        result(1, "w19_two", 36'h7FFFE, 1'b0, 8'd2);
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++)
            beat(1, 18'h3FFFF, 1'b0, j == 2);
        drive(1, 1'b0, 18'h0, 1'b0, 1'b0);
        result(1, "w19_wrap", 36'h3FFFD, 1'b1, 8'd3);
        @(posedge clk);
        #1;

        // Count saturates at 255 on a 260-beat vector.
        for (int j = 0; j < 260; j++)
            beat(1, 18'd0, 1'b0, j == 259);
        drive(1, 1'b0, 18'h0, 1'b0, 1'b0);
        result(1, "sat", 36'd0, 1'b0, 8'd255);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dot_product_accumulator_9bits.md
# dot_product_accumulator_9bits

Sequential accumulation stage directly downstream of the 9×9 PIRDSP multiplier. It consumes the 18-bit product `C` one beat per cycle over a valid/ready handshake and sums a vector of products into a wide accumulator. On the last beat it presents the dot-product result, an overflow flag and a beat count over an output valid/ready handshake. The multiplier's `A_sign | B_sign` selects how each product is extended before it is summed.

## Interface
- `ACC_WIDTH`, default 36: accumulator and result width; must be ≥ 19.
- `CNT_WIDTH`, default 8: width of the beat counter.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, synchronous and active-high.
- `in_valid` input 1: a product beat is present.
- `in_ready` output 1: the block accepts the beat this cycle.
- `in_product` input 18: multiplier output `C`.
- `in_signed` input 1: the product is two's complement (`A_sign | B_sign`); 0 means unsigned.
- `in_last` input 1: the beat is the final element of the vector.
- `out_valid` output 1: a result is held.
- `out_ready` input 1: the consumer takes the result.
- `out_acc` output ACC_WIDTH: the dot-product sum.
- `out_overflow` output 1: the sum left the ACC_WIDTH range at least once during the vector.
- `out_count` output CNT_WIDTH: number of beats in the vector; saturates at all-ones.

## Operation
- State machine states: IDLE (no vector open), ACCUM (vector open), HOLD (result presented).
- Beat accepted = `in_valid & in_ready`. Result taken = `out_valid & out_ready`.
- `in_ready` = (state != HOLD) | `out_ready`.
- Extension of each product:
  - If the vector's mode is signed: sign-extend 18 → ACC_WIDTH.
  - Otherwise: zero-extend.
- Mode latch: `in_signed` is sampled on the first beat of a vector (beat accepted in IDLE, or in HOLD while the result is taken). It is held until `in_last`; changes of `in_signed` mid-vector are ignored.
- Accumulation: `acc_next` = (first beat ? 0 : acc) + extended product, computed at ACC_WIDTH+1 bits.
- Overflow, sticky per vector, cleared on the first beat:
  - Signed mode: set when bit ACC_WIDTH differs from bit ACC_WIDTH-1 of the (ACC_WIDTH+1)-bit sum.
  - Unsigned mode: set on carry-out at bit ACC_WIDTH.
  - The stored acc always wraps modulo 2^ACC_WIDTH.
- Count: reset to 1 on the first beat; incremented on each further beat; saturates at 2^CNT_WIDTH-1.
- Transitions:
  - IDLE → ACCUM: beat accepted, `in_last`=0.
  - IDLE → HOLD: beat accepted, `in_last`=1 (single-element vector).
  - ACCUM → ACCUM: beat accepted, `in_last`=0.
  - ACCUM → HOLD: beat accepted, `in_last`=1.
  - ACCUM with no beat: hold.
  - HOLD, result taken, no beat → IDLE.
  - HOLD, result taken, beat accepted → ACCUM, or HOLD if that beat has `in_last`=1; the new vector starts from 0.
  - HOLD, result not taken: hold; outputs stable; `in_ready`=0.
- On entry to HOLD, `out_acc`, `out_overflow` and `out_count` are registered from the final sum, flag and count. They do not change while `out_valid` is 1 and the result is not taken.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_acc`=0, `out_overflow`=0, `out_count`=0, internal acc=0. `in_ready` is 1 in the cycle after reset deasserts.
- Reset asserted mid-vector or in HOLD discards the partial sum and any pending result. No output is produced for that vector.
- Latency: `out_valid` rises in the cycle after the `in_last` beat is accepted (1 cycle).
- Throughput: one beat per cycle, with no bubbles between vectors when `out_ready`=1 on the result cycle.
- Back-pressure: `in_ready` depends combinationally on `out_ready`; no other combinational input-to-output paths.

## Structure
- Shared package `pirdsp_acc_pkg`:
  - State enum (IDLE/ACCUM/HOLD).
  - `PRODUCT_WIDTH`=18.
  - Extend function (product, signed flag, width).
- One natural sub-module, `sat_counter` (CNT_WIDTH, synchronous load-to-1 / increment / saturate), used for `out_count`.
- Everything else stays flat in the top module.

## Test plan
- Signed vector, `in_product` = 0x3FFFF (-1), 0x00005, 0x3FFFE (-2) with `in_last` on the third beat, `out_ready`=1 → `out_valid` one cycle later; `out_acc`=2; `out_overflow`=0; `out_count`=3.
- Unsigned single beat 0x3FFFF with `in_last`=1 → `out_acc`=262143; `out_count`=1; IDLE→HOLD→IDLE.
- ACC_WIDTH=19, unsigned, two beats of 0x3FFFF → `out_acc`=0x7FFFE; no overflow. Add a third beat → wraps to 0x3FFFD with `out_overflow`=1.
- Back-pressure: result held with `out_ready`=0 for 4 cycles → `in_ready`=0, outputs stable. Then `out_ready`=1 together with a new beat → result taken and new vector accumulates from 0.
- Reset asserted after 2 of 4 beats → `out_valid` stays 0. The next full vector of 1,1,1 gives `out_acc`=3, `out_count`=3.
- `in_signed` toggled mid-vector (1 on the first beat, then 0) → all beats are sign-extended; 0x20000 ×2 gives `out_acc` = -262144 (two's complement in ACC_WIDTH).
